// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing the fifo3 byte write port between two producers.
// Latency : grant registered one edge after a request in IDLE; ack/w_en combinational in the granted cycle.
// Backpres: fifo_full stalls the owner (holds grant, no beat); a producer holds req until acked.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0/data0/ack0             producer 0 request, byte, combinational accept
//   req1/data1/ack1             producer 1 request, byte, combinational accept
//   fifo_full                   fifo3 full flag (write is suppressed while high)
//   fifo_w_en / fifo_data_w     fifo3 write strobe and byte, muxed from the owner
//   owner                       registered grant: 00 none, 01 producer 0, 10 producer 1
//   cnt0 / cnt1                 registered wrapping counts of accepted bytes
module fifo_wr_arbiter #(
    parameter int BURST = 4,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [7:0]    data0,
    output logic          ack0,
    input  logic          req1,
    input  logic [7:0]    data1,
    output logic          ack1,
    input  logic          fifo_full,
    output logic          fifo_w_en,
    output logic [7:0]    fifo_data_w,
    output logic [1:0]    owner,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0] BURST_B  = BW'(BURST);
    localparam logic [BW-1:0] BURST_M1 = BW'(BURST - 1);

    // Encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERVE0 = 2'b01,
        SERVE1 = 2'b10
    } state_e;

    state_e         state_q, state_d;
    logic           last_q, last_d;
    logic [BW-1:0]  beats_q, beats_d;
    logic [CW-1:0]  cnt0_q, cnt0_d;
    logic [CW-1:0]  cnt1_q, cnt1_d;

    // Owner-relative views of the two producers; sel picks producer 1.
    logic       sel;
    logic       req_own;
    logic       req_oth;
    logic [7:0] data_own;
    logic       xfer;
    logic       done;

    assign sel      = (state_q == SERVE1);
    assign req_own  = sel ? req1 : req0;
    assign req_oth  = sel ? req0 : req1;
    assign data_own = sel ? data1 : data0;

    // A stalled owner (full) keeps its grant; the burst limit blocks a
    // further byte even if the exit somehow has not happened yet.
    assign xfer = (state_q == SERVE0 || state_q == SERVE1) && req_own &&
                  !fifo_full && (beats_q < BURST_B);

    // Grant ends when the owner lets go, or this byte completes the burst.
    assign done = !req_own || (xfer && (beats_q == BURST_M1));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        beats_d     = beats_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        ack0        = 1'b0;
        ack1        = 1'b0;
        fifo_w_en   = 1'b0;
        fifo_data_w = 8'h00;

        case (state_q)
            IDLE: begin
                // On a tie, the producer that was not served last wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = SERVE0;
                    beats_d = '0;
                end else if (req1) begin
                    state_d = SERVE1;
                    beats_d = '0;
                end
            end

            SERVE0, SERVE1: begin
                if (xfer) begin
                    fifo_w_en   = 1'b1;
                    fifo_data_w = data_own;
                    beats_d     = beats_q + BW'(1);
                    if (sel) begin
                        ack1   = 1'b1;
                        cnt1_d = cnt1_q + CW'(1);
                    end else begin
                        ack0   = 1'b1;
                        cnt0_d = cnt0_q + CW'(1);
                    end
                end

                if (done) begin
                    last_d  = sel;
                    beats_d = '0;
                    // Hand straight over to a waiting rival, otherwise
                    // re-grant the same producer with no bubble.
                    if (req_oth) begin
                        state_d = sel ? SERVE0 : SERVE1;
                    end else if (req_own) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                beats_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            beats_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            beats_q <= beats_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign owner = state_q;
    assign cnt0  = cnt0_q;
    assign cnt1  = cnt1_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose : directed bench for fifo_wr_arbiter with a per-cycle reference model.
// Latency : inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpres: producers hold their head byte until the falling-edge sample shows req & ack.
module tb_fifo_wr_arbiter;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0;
    logic [7:0]  data0 = 8'h00;
    logic        req1 = 1'b0;
    logic [7:0]  data1 = 8'h00;
    logic        fifo_full = 1'b0;
    logic        ack0, ack1, fifo_w_en;
    logic [7:0]  fifo_data_w;
    logic [1:0]  owner;
    logic [15:0] cnt0, cnt1;
    // Narrow-counter instance on the same inputs
    logic        a4_ack0, a4_ack1, w4_en;
    logic [7:0]  w4_dat;
    logic [1:0]  o4;
    logic [3:0]  c4_0, c4_1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    fifo_wr_arbiter #(.BURST(BURST), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .fifo_full(fifo_full), .fifo_w_en(fifo_w_en), .fifo_data_w(fifo_data_w),
        .owner(owner), .cnt0(cnt0), .cnt1(cnt1)
    );

    fifo_wr_arbiter #(.BURST(BURST), .CW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .ack0(a4_ack0),
        .req1(req1), .data1(data1), .ack1(a4_ack1),
        .fifo_full(fifo_full), .fifo_w_en(w4_en), .fifo_data_w(w4_dat),
        .owner(o4), .cnt0(c4_0), .cnt1(c4_1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner code: 0 none, 1 producer 0, 2 producer 1
    int m_own = 0;
    int m_taken = 0;
    int m_last = 1;
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    function automatic logic req_of(input int p);
        return (p == 0) ? req0 : req1;
    endfunction

    // Grant goes to the preferred producer if it asks, else the other one.
    function automatic int pick(input int pref);
        if (req_of(pref)) return pref + 1;
        if (req_of(1 - pref)) return 2 - pref;
        return 0;
    endfunction

    function automatic logic m_xfer();
        return (m_own != 0) && req_of(m_own - 1) && !fifo_full && (m_taken < BURST);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own   <= 0;
            m_taken <= 0;
            m_last  <= 1;
            m_cnt0  <= 0;
            m_cnt1  <= 0;
        end else if (m_own == 0) begin
            m_own   <= pick(1 - m_last);
            m_taken <= 0;
        end else begin
            if (m_xfer()) begin
                if (m_own == 1) m_cnt0 <= m_cnt0 + 1;
                else            m_cnt1 <= m_cnt1 + 1;
            end
            if (!req_of(m_own - 1) || (m_xfer() && m_taken + 1 == BURST)) begin
                m_last  <= m_own - 1;
                m_own   <= pick(2 - m_own);
                m_taken <= 0;
            end else begin
                m_taken <= m_taken + (m_xfer() ? 1 : 0);
            end
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        logic x;
        logic [7:0] d;
        x = m_xfer();
        d = !x ? 8'h00 : (m_own == 1 ? data0 : data1);
        check("owner", owner, m_own);
        check("w_en", fifo_w_en, x);
        check("ack0", ack0, x && m_own == 1);
        check("ack1", ack1, x && m_own == 2);
        check("data_w", fifo_data_w, d);
        check("cnt0", cnt0, m_cnt0 % 65536);
        check("cnt1", cnt1, m_cnt1 % 65536);
        check("write_while_full", fifo_w_en & fifo_full, 0);
        check("w4_owner", o4, m_own);
        check("w4_w_en", w4_en, x);
        check("w4_acks", {a4_ack1, a4_ack0}, {x && m_own == 2, x && m_own == 1});
        check("w4_data", w4_dat, d);
        check("w4_cnt0", c4_0, m_cnt0 % 16);
        check("w4_cnt1", c4_1, m_cnt1 % 16);
    end

    // ---------------- producers and write log ----------------
    typedef struct {
        int p;
        int d;
        int c;
    } wr_t;
    wr_t wlog[$];
    logic tk0 = 1'b0;
    logic tk1 = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always @(negedge clk) begin
        tk0 <= req0 & ack0;
        tk1 <= req1 & ack1;
        if (fifo_w_en) wlog.push_back('{ack1 ? 1 : 0, int'(fifo_data_w), cyc});
    end

    task automatic drive();
        req0  = (q0.size() != 0);
        data0 = req0 ? q0[0] : 8'h00;
        req1  = (q1.size() != 0);
        data1 = req1 ? q1[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tk0 && q0.size() > 0) void'(q0.pop_front());
        if (tk1 && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(name, q0.size() + q1.size(), 0);
    endtask

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        #20;
        check("rst_owner", owner, 2'b00);
        check("rst_w_en", fifo_w_en, 1'b0);
        check("rst_cnt0", cnt0, 16'd0);
        check("rst_cnt1", cnt1, 16'd0);
        #5 rst_n = 1'b1;
        tick();

        // Single producer: 1, 2, 3
        wlog.delete();
        q0.push_back(8'd1); q0.push_back(8'd2); q0.push_back(8'd3);
        drive();
        tick();
        check("single_owner_grant", owner, 2'b01);
        wait_empty(20, "single_drain");
        tick();
        check("single_owner_release", owner, 2'b00);
        check("single_cnt0", cnt0, 16'd3);
        check("single_nwr", wlog.size(), 3);
        if (wlog.size() == 3) begin
            for (int i = 0; i < 3; i++) check("single_data", wlog[i].d, i + 1);
            check("single_consec", wlog[2].c - wlog[0].c, 2);
        end

        // Reset mid-burst
        for (int i = 0; i < 4; i++) q0.push_back(8'hA0 + 8'(i));
        drive();
        tick();
        tick();
        check("midrst_pre_wen", fifo_w_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wen", fifo_w_en, 1'b0);
        check("midrst_ack0", ack0, 1'b0);
        check("midrst_data", fifo_data_w, 8'h00);
        check("midrst_owner", owner, 2'b00);
        check("midrst_cnt0", cnt0, 16'd0);
        q0.delete();
        drive();
        #3 rst_n = 1'b1;
        tick();

        // Contention
        wlog.delete();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'h10 + 8'(i));
            q1.push_back(8'h20 + 8'(i));
        end
        drive();
        wait_empty(60, "cont_drain");
        check("cont_nwr", wlog.size(), 16);
        if (wlog.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("cont_prod", wlog[i].p, (i / 4) % 2);
                check("cont_data", wlog[i].d,
                      (((i / 4) % 2) == 1 ? 32'h20 : 32'h10) + (i / 8) * 4 + (i % 4));
            end
            check("cont_no_gap", wlog[15].c - wlog[0].c, 15);
        end
        check("cont_cnt0", cnt0, 16'd8);
        check("cont_cnt1", cnt1, 16'd8);
        tick();

        // Full stall after the 2nd byte of a producer 1 burst
        wlog.delete();
        for (int i = 0; i < 4; i++) q1.push_back(8'h30 + 8'(i));
        drive();
        for (int n = 0; n < 20 && wlog.size() < 2; n++) tick();
        check("stall_two_written", wlog.size(), 2);
        fifo_full = 1'b1;
        q0.push_back(8'h40);
        drive();
        #1;
        for (int k = 0; k < 3; k++) begin
            check("stall_wen", fifo_w_en, 1'b0);
            check("stall_ack1", ack1, 1'b0);
            check("stall_owner", owner, 2'b10);
            tick();
        end
        fifo_full = 1'b0;
        wait_empty(30, "stall_drain");
        check("stall_nwr", wlog.size(), 5);
        if (wlog.size() == 5) begin
            for (int i = 0; i < 4; i++) check("stall_data", wlog[i].d, 32'h30 + i);
            check("stall_gap", wlog[2].c - wlog[1].c, 4);
            check("stall_tail", wlog[3].c - wlog[2].c, 1);
            check("stall_handover_prod", wlog[4].p, 0);
            check("stall_handover_gap", wlog[4].c - wlog[3].c, 1);
        end
        tick();
        tick();

        // Full while the grant is made
        wlog.delete();
        fifo_full = 1'b1;
        q0.push_back(8'h50); q0.push_back(8'h51);
        drive();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("fullgrant_owner", owner, 2'b01);
            check("fullgrant_wen", fifo_w_en, 1'b0);
        end
        fifo_full = 1'b0;
        #1;
        check("fullgrant_first_wen", fifo_w_en, 1'b1);
        check("fullgrant_first_ack0", ack0, 1'b1);
        check("fullgrant_first_data", fifo_data_w, 8'h50);
        wait_empty(20, "fullgrant_drain");
        check("fullgrant_nwr", wlog.size(), 2);
        tick();
        tick();

        // Counter wrap on the CW=4 instance
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        wlog.delete();
        for (int i = 0; i < 17; i++) q1.push_back(8'h60 + 8'(i));
        drive();
        wait_empty(60, "wrap_drain");
        check("wrap_cnt1_cw4", c4_1, 4'd1);
        check("wrap_cnt1_cw16", cnt1, 16'd17);
        check("wrap_nwr", wlog.size(), 17);
        if (wlog.size() == 17) check("wrap_no_gap", wlog[16].c - wlog[0].c, 16);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the 8-bit write side of the byte-in / 3-bit-out FIFO (`fifo3`) between two byte producers. Each producer presents a valid/ready-style request. The arbiter grants the FIFO write port to one producer at a time, for a burst of up to `BURST` bytes. It never writes while the FIFO reports `full`, so the FIFO's `overflow` flag cannot be raised through this block. It sits directly in front of `fifo3`: its `fifo_w_en`/`fifo_data_w` drive the FIFO's `w_en`/`data_w`, and it takes `full` back as `fifo_full`.

## Interface
- `BURST`, default 4: maximum bytes accepted from one producer per grant; range 1..15.
- `CW`, default 16: width of the per-producer accepted-byte counters.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`  in  1  producer 0 has a valid byte on `data0`; held until accepted.
- `data0`  in  8  producer 0 byte; stable while `req0`=1 and not yet accepted.
- `ack0`  out  1  combinational; producer 0 byte is taken at this rising edge.
- `req1`, `data1`, `ack1`: same as the producer 0 signals, for producer 1.
- `fifo_full`  in  1  FIFO cannot accept another byte (fifo3 `full`).
- `fifo_w_en`  out  1  combinational FIFO write strobe.
- `fifo_data_w`  out  8  combinational byte to FIFO, muxed from the owner.
- `owner`  out  2  registered grant state: 00 = none, 01 = producer 0, 10 = producer 1.
- `cnt0`  out  CW  registered count of bytes accepted from producer 0; wraps modulo 2^CW.
- `cnt1`  out  CW  same as `cnt0`, for producer 1.

## Operation
- FSM states: `IDLE`, `SERVE0`, `SERVE1`.
- Registered state also includes:
  - `last`: 1 bit, the last producer served.
  - `beats`: a counter of width $clog2(BURST+1).
- Transfer condition, for producer x while in `SERVEx`: `xfer` = `req_x` & ~`fifo_full` & (`beats` < `BURST`).
- When `xfer` is true:
  - `fifo_w_en` = 1.
  - `ack_x` = 1.
  - `fifo_data_w` = `data_x`.
- Otherwise:
  - `fifo_w_en` = 0.
  - Both acks = 0.
  - `fifo_data_w` = 0.
- The non-owner's ack is always 0.
- On each `xfer` edge:
  - `beats` increments.
  - `cnt_x` increments (wrapping from 2^CW−1 to 0).
- Grant decision from `IDLE`:
  - Only one request pending: that producer gets the grant.
  - Both requests pending: the producer ≠ `last` gets the grant.
  - On grant, `beats` is cleared to 0.
- `fifo_full` does not block a grant; it only stalls transfers.
- Exit from `SERVEx` is evaluated on each edge. The grant ends when either:
  - `req_x` = 0 (no transfer this edge), or
  - this edge's transfer brings `beats` to `BURST`.
- On exit, `last` = x, and the next state is chosen as:
  - other producer requesting: `SERVE_other`, `beats` = 0;
  - else `req_x` still high: `SERVEx` again, `beats` = 0 (a one-cycle gap is not required);
  - else `IDLE`.
- A `fifo_full` stall:
  - holds the grant;
  - does not advance `beats`;
  - does not end the burst.
- `owner` mirrors the state encoding.

## Timing
- Reset (async assert), all outputs and registers:
  - state = `IDLE`;
  - `last` = 1, so producer 0 wins the first tie;
  - `beats` = 0, `cnt0` = `cnt1` = 0, `owner` = 00;
  - `fifo_w_en` = `ack0` = `ack1` = 0, `fifo_data_w` = 0.
- Reset asserted mid-burst: outputs drop immediately. No partial write is issued after reset assertion.
- Deassertion is synchronised externally; the first active edge after deassertion may grant.
- Latency:
  - `req_x` rises before edge N while in `IDLE`: `owner` changes after edge N.
  - First `ack_x` and `fifo_w_en` occur during cycle N→N+1; the byte is written at edge N+1.
- Throughput: one byte per cycle while the owner requests and the FIFO is not full.
- Handover between producers costs zero idle cycles: the last byte of A is written at edge M, and the first byte of B is written at edge M+1.
- Handshake rule: a byte is consumed exactly at an edge with `req_x` & `ack_x`. A producer may drop `req_x` only after that edge.
- `fifo_full` is sampled combinationally in the same cycle. A `full` that rises after a write is honoured on the next cycle with no lost or extra write.

## Test plan
- **Reset:** hold `rst_n`=0 for 25 ns, then release.
  - Required: `owner`=00, `fifo_w_en`=0, `cnt0`=`cnt1`=0.
  - Pulse `rst_n` low mid-burst: all outputs return to 0 asynchronously.
- **Single producer:** `req0` with bytes 1, 2, 3, then drop.
  - Required: `owner`=01 one edge after `req0`.
  - `fifo_data_w` = 1, 2, 3 on consecutive cycles; `cnt0`=3; `owner`=00 after release.
- **Contention:** `req0` and `req1` held continuously, `BURST`=4.
  - Required write order: four bytes from producer 0, four from producer 1, then repeating.
  - No idle cycle between bursts; `cnt0`=`cnt1`=8 after 16 writes.
- **Full stall:** `fifo_full`=1 for 3 cycles after the 2nd byte of a producer 1 burst.
  - Required: `fifo_w_en`=`ack1`=0 for those 3 cycles, `owner` stays 10.
  - Remaining 2 bytes follow, then the grant passes on.
- **Full at grant:** `fifo_full`=1 while `req0` rises, cleared after 5 cycles.
  - Required: `owner`=01 with no write while full.
  - First write in the cycle `fifo_full` drops; the fifo3 `overflow` flag never asserts.
- **Counter wrap:** with `CW`=4, accept 17 bytes from producer 1.
  - Required: `cnt1`=1 at the end.
